// File: rtl/fe2de_pkg.sv
// Shared types and constants for the fetch-to-decode queue and its branch-target capture table.
package fe2de_pkg;

    // Widest interrupt cause code a packet can carry; narrower CAUSE_W values are zero-extended.
    localparam int CAUSE_W_MAX = 16;

    // Instruction presented to decode when the queue is empty.
    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic [31:0]            pc;
        logic [31:0]            instr;
        logic                   rv16;
        logic                   is_x1;
        logic                   is_xn;
        logic                   pred_taken;
        logic                   g_int;
        logic [CAUSE_W_MAX-1:0] causecode;
    } fe2de_pkt_t;

    // Compressed packets carry their raw 16-bit instruction in the low half.
    function automatic logic [31:0] expand_instr(input logic        rv16,
                                                 input logic [15:0] rv16_instr,
                                                 input logic [31:0] instr);
        return rv16 ? {16'h0, rv16_instr} : instr;
    endfunction

endpackage

// File: rtl/fe2de_btb.sv
// Branch-target capture table: records {pc, instr} of decoded redirecting branches and
// answers fetch lookups combinationally once the post-reset warm-up has elapsed.
module fe2de_btb
    import fe2de_pkg::*;
#(
    parameter int BTB_ENTRIES = 4,
    parameter int BTB_DLY     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de2fe_branch,
    input  logic        de2ex_inst_valid,
    input  logic        de_valid,
    input  logic [31:0] de_pc,
    input  logic [31:0] de_instr,
    input  logic [31:0] lookup_pc,
    output logic        btb_valid,
    output logic        btb_hit,
    output logic [31:0] btb_hit_instr
);

    localparam int          PW   = (BTB_ENTRIES > 1) ? $clog2(BTB_ENTRIES) : 1;
    localparam logic [PW-1:0] LAST = PW'(BTB_ENTRIES - 1);
    localparam logic [3:0]  DLY  = 4'(BTB_DLY);

    logic [31:0]            ent_pc  [BTB_ENTRIES];
    logic [31:0]            ent_ins [BTB_ENTRIES];
    logic [BTB_ENTRIES-1:0] ent_vld;
    logic [PW-1:0]          rr_ptr;
    logic                   arm;
    logic [3:0]             wu_cnt;

    logic                   cap_we;
    logic                   cap_match;
    logic [PW-1:0]          cap_idx;
    logic [PW-1:0]          wr_idx;
    logic                   look_hit;
    logic [31:0]            look_ins;

    assign cap_we    = arm & de2ex_inst_valid & de_valid;
    assign wr_idx    = cap_match ? cap_idx : rr_ptr;
    assign btb_valid = (wu_cnt == DLY);
    assign btb_hit   = btb_valid & look_hit;
    assign btb_hit_instr = btb_hit ? look_ins : 32'h0;

    // Find an existing entry for the captured pc; descending scan leaves the lowest index.
    always_comb begin
        cap_match = 1'b0;
        cap_idx   = '0;
        for (int i = BTB_ENTRIES - 1; i >= 0; i--) begin
            if (ent_vld[i] && (ent_pc[i] == de_pc)) begin
                cap_match = 1'b1;
                cap_idx   = PW'(i);
            end
        end
    end

    // Fetch lookup against all valid entries; lowest matching index wins.
    always_comb begin
        look_hit = 1'b0;
        look_ins = 32'h0;
        for (int i = BTB_ENTRIES - 1; i >= 0; i--) begin
            if (ent_vld[i] && (ent_pc[i] == lookup_pc)) begin
                look_hit = 1'b1;
                look_ins = ent_ins[i];
            end
        end
    end

    // Control state: capture arm (clear beats set), valid bits, round-robin pointer, warm-up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm     <= 1'b0;
            ent_vld <= '0;
            rr_ptr  <= '0;
            wu_cnt  <= '0;
        end else begin
            if (cap_we) begin
                arm             <= 1'b0;
                ent_vld[wr_idx] <= 1'b1;
                if (!cap_match) begin
                    rr_ptr <= (rr_ptr == LAST) ? '0 : rr_ptr + 1'b1;
                end
            end else if (de2fe_branch) begin
                arm <= 1'b1;
            end
            if (wu_cnt != DLY) begin
                wu_cnt <= wu_cnt + 1'b1;
            end
        end
    end

    // Entry payload; meaningless until the matching valid bit is set, so not reset.
    always_ff @(posedge clk) begin
        if (cap_we) begin
            ent_pc[wr_idx]  <= de_pc;
            ent_ins[wr_idx] <= de_instr;
        end
    end

endmodule

// File: rtl/fe2de_queue.sv
// Fetch-to-decode packet FIFO with flush, NOP presentation when empty, backpressure to
// fetch, and the branch-target capture table fed from the decode head.
module fe2de_queue
    import fe2de_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int BTB_ENTRIES = 4,
    parameter int BTB_DLY     = 10,
    parameter int CAUSE_W     = 5
) (
    input  logic               clk,
    input  logic               cpurst,
    input  logic               fe_valid,
    output logic               fe_ready,
    input  logic [31:0]        fe_pc,
    input  logic [31:0]        fe_instr,
    input  logic               fe_rv16,
    input  logic [15:0]        fe_rv16_instr,
    input  logic               fe_is_x1,
    input  logic               fe_is_xn,
    input  logic               fe_pred_taken,
    input  logic               fe_g_int,
    input  logic [CAUSE_W-1:0] fe_causecode,
    input  logic               stall,
    input  logic               fet_flush,
    input  logic               branch_predict_err,
    input  logic               fence_stall,
    output logic               de_valid,
    output logic [31:0]        de_pc,
    output logic [31:0]        de_instr,
    output logic               de_rv16,
    output logic               de_is_x1,
    output logic               de_is_xn,
    output logic               de_pred_taken,
    output logic               de_g_int,
    output logic [CAUSE_W-1:0] de_causecode,
    input  logic               de2fe_branch,
    input  logic               de2ex_inst_valid,
    input  logic [31:0]        lookup_pc,
    output logic               btb_valid,
    output logic               btb_hit,
    output logic [31:0]        btb_hit_instr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    fe2de_pkt_t    mem [DEPTH];
    fe2de_pkt_t    wr_pkt;
    fe2de_pkt_t    head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          flush_now;
    logic          push;
    logic          pop;

    // Flush requests are only honoured when nothing downstream is stalled.
    assign flush_now = (fet_flush | branch_predict_err | fence_stall) & ~stall;
    assign fe_ready  = (count != FULL);
    assign de_valid  = (count != '0);
    assign push      = fe_valid & fe_ready & ~flush_now;
    assign pop       = de_valid & ~stall;

    // Assemble the stored packet; compressed instructions are expanded once, at push.
    always_comb begin
        wr_pkt            = '0;
        wr_pkt.pc         = fe_pc;
        wr_pkt.instr      = expand_instr(fe_rv16, fe_rv16_instr, fe_instr);
        wr_pkt.rv16       = fe_rv16;
        wr_pkt.is_x1      = fe_is_x1;
        wr_pkt.is_xn      = fe_is_xn;
        wr_pkt.pred_taken = fe_pred_taken;
        wr_pkt.g_int      = fe_g_int;
        wr_pkt.causecode  = CAUSE_W_MAX'(fe_causecode);
    end

    // Pointer and occupancy tracking; flush empties the queue and drops a same-cycle push.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_now) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Packet storage; occupancy decides what is live, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_pkt;
    end

    // Present the head packet, or an all-zero NOP when the queue is empty.
    always_comb begin
        head       = '0;
        head.instr = NOP_INSTR;
        if (de_valid) head = mem[rd_ptr];
    end

    assign de_pc         = head.pc;
    assign de_instr      = head.instr;
    assign de_rv16       = head.rv16;
    assign de_is_x1      = head.is_x1;
    assign de_is_xn      = head.is_xn;
    assign de_pred_taken = head.pred_taken;
    assign de_g_int      = head.g_int;
    assign de_causecode  = head.causecode[CAUSE_W-1:0];

    fe2de_btb #(
        .BTB_ENTRIES (BTB_ENTRIES),
        .BTB_DLY     (BTB_DLY)
    ) u_btb (
        .clk              (clk),
        .rst              (cpurst),
        .de2fe_branch     (de2fe_branch),
        .de2ex_inst_valid (de2ex_inst_valid),
        .de_valid         (de_valid),
        .de_pc            (de_pc),
        .de_instr         (de_instr),
        .lookup_pc        (lookup_pc),
        .btb_valid        (btb_valid),
        .btb_hit          (btb_hit),
        .btb_hit_instr    (btb_hit_instr)
    );

endmodule
